// File: rtl/pulse_sched.sv
// pulse_sched: round-robin burst strobe scheduler for asynchronous trigger sources.
// Optional abort input enabled by defining PULSE_SCHED_ABORT_EN.
module pulse_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int GAP_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] start,
`ifdef PULSE_SCHED_ABORT_EN
  input  logic             abort,
`endif
  input  logic [GAP_W-1:0] gap,
  input  logic [CNT_W-1:0] burst,
  output logic             pulse,
  output logic [ID_W-1:0]  pulse_id,
  output logic             done,
  output logic             busy,
  output logic [N_REQ-1:0] pending
);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  state_t state, state_n;
  logic [N_REQ-1:0] s1, s2, s3, rise, pending_n;
  logic [ID_W-1:0]  last, last_n, id_n, sel;
  logic [GAP_W-1:0] gap_r, gap_r_n, gcnt, gcnt_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic found, kill;
`ifdef PULSE_SCHED_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif
  // Chain resets high so a start held through reset release is not seen as a rise.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '1;
      s2 <= '1;
      s3 <= '1;
    end else begin
      s1 <= start;
      s2 <= s1;
      s3 <= s2;
    end
  assign rise = s2 & ~s3;
  // Wrapped bits (<= last) first, then the nearest bit above last overrides.
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (pending[i]) begin
        sel = ID_W'(i);
        found = 1'b1;
      end
    for (int i = N_REQ - 1; i >= 0; i--)
      if (pending[i] && ID_W'(i) > last) sel = ID_W'(i);
  end
  always_comb begin
    state_n = state;
    pending_n = pending;
    last_n = last;
    id_n = pulse_id;
    gap_r_n = gap_r;
    gcnt_n = gcnt;
    rem_n = rem;
    case (state)
      IDLE:
        if (found) begin
          state_n = PULSE;
          pending_n = pending & ~(N_REQ'(1) << sel);
          last_n = sel;
          id_n = sel;
          gap_r_n = gap;
          rem_n = (burst == '0) ? '0 : burst - CNT_W'(1);
        end
      PULSE:
        if (gap_r == '0) begin
          if (rem != '0) rem_n = rem - CNT_W'(1);
          else state_n = IDLE;
        end else begin
          gcnt_n = gap_r - GAP_W'(1);
          state_n = GAP;
        end
      GAP:
        if (gcnt != '0) gcnt_n = gcnt - GAP_W'(1);
        else if (rem != '0) begin
          rem_n = rem - CNT_W'(1);
          state_n = PULSE;
        end else state_n = IDLE;
      default: state_n = IDLE;
    endcase
    pending_n = pending_n | rise;
    if (kill) begin
      state_n = IDLE;
      pending_n = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pending <= '0;
      last <= ID_W'(N_REQ - 1);
      pulse_id <= '0;
      gap_r <= '0;
      gcnt <= '0;
      rem <= '0;
    end else begin
      state <= state_n;
      pending <= pending_n;
      last <= last_n;
      pulse_id <= id_n;
      gap_r <= gap_r_n;
      gcnt <= gcnt_n;
      rem <= rem_n;
    end
  assign pulse = (state == PULSE);
  assign busy = (state != IDLE);
  assign done = pulse && (rem == '0);
endmodule

// File: tb/tb_pulse_sched.sv
// tb_pulse_sched: directed self-checking bench for pulse_sched.
module tb_pulse_sched;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] start;
  logic [7:0] gap, burst;
  logic pulse, done, busy;
  logic [1:0] pulse_id;
  logic [3:0] pending;
`ifdef PULSE_SCHED_ABORT_EN
  logic abort;
`endif
  int ncmp = 0;
  int nerr = 0;
  int npulse;
  logic [6:1] pexp, dexp;

  pulse_sched dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
`ifdef PULSE_SCHED_ABORT_EN
    .abort(abort),
`endif
    .gap(gap),
    .burst(burst),
    .pulse(pulse),
    .pulse_id(pulse_id),
    .done(done),
    .busy(busy),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pulse(input string tag, input int max, input logic [1:0] exp_id);
    int n = 0;
    while (!pulse && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, {31'd0, pulse}, 32'd1);
    chk({tag, "_id"}, {30'd0, pulse_id}, {30'd0, exp_id});
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 4'b0001;
    gap = 8'd3;
    burst = 8'd1;
`ifdef PULSE_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    pexp = 6'b100100;
    dexp = 6'b100000;
    repeat (3) @(negedge clk);
    chk("rst_pulse", {31'd0, pulse}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pending", {28'd0, pending}, 32'd0);
    chk("rst_id", {30'd0, pulse_id}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_pulse", {31'd0, pulse}, 32'd0);
      chk("hold_pending", {28'd0, pending}, 32'd0);
    end
    start = 4'b0000;
    repeat (4) @(negedge clk);
    // single pulse, gap 3
    start = 4'b0100;
    repeat (3) @(negedge clk);
    chk("lat_pending", {28'd0, pending}, 32'h4);
    chk("lat_early", {31'd0, pulse}, 32'd0);
    @(negedge clk);
    chk("s_pulse", {31'd0, pulse}, 32'd1);
    chk("s_id", {30'd0, pulse_id}, 32'd2);
    chk("s_done", {31'd0, done}, 32'd1);
    chk("s_busy", {31'd0, busy}, 32'd1);
    chk("s_pending", {28'd0, pending}, 32'd0);
    start = 4'b0000;
    gap = 8'd7;
    burst = 8'd9;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("s_gap_pulse", {31'd0, pulse}, 32'd0);
      chk("s_gap_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    chk("s_busy_drop", {31'd0, busy}, 32'd0);
    // burst 3, gap 2
    start = 4'b0010;
    gap = 8'd2;
    burst = 8'd3;
    repeat (4) @(negedge clk);
    chk("b3_pulse0", {31'd0, pulse}, 32'd1);
    chk("b3_id", {30'd0, pulse_id}, 32'd1);
    chk("b3_done0", {31'd0, done}, 32'd0);
    start = 4'b0000;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("b3_pulse", {31'd0, pulse}, {31'd0, pexp[i]});
      chk("b3_done", {31'd0, done}, {31'd0, dexp[i]});
    end
    repeat (3) @(negedge clk);
    chk("b3_idle", {31'd0, busy}, 32'd0);
    // burst 0 acts as 1
    start = 4'b0010;
    burst = 8'd0;
    repeat (4) @(negedge clk);
    chk("b0_pulse", {31'd0, pulse}, 32'd1);
    chk("b0_done", {31'd0, done}, 32'd1);
    chk("b0_id", {30'd0, pulse_id}, 32'd1);
    start = 4'b0000;
    @(negedge clk);
    chk("b0_single", {31'd0, pulse}, 32'd0);
    repeat (2) @(negedge clk);
    chk("b0_idle", {31'd0, busy}, 32'd0);
    // gap 0, burst 4: back-to-back pulses
    start = 4'b1000;
    gap = 8'd0;
    burst = 8'd4;
    repeat (4) @(negedge clk);
    chk("g0_pulse0", {31'd0, pulse}, 32'd1);
    chk("g0_id", {30'd0, pulse_id}, 32'd3);
    chk("g0_done0", {31'd0, done}, 32'd0);
    start = 4'b0000;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("g0_pulse", {31'd0, pulse}, 32'd1);
      chk("g0_done", {31'd0, done}, (i == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("g0_end_pulse", {31'd0, pulse}, 32'd0);
    chk("g0_end_busy", {31'd0, busy}, 32'd0);
    // round robin
    gap = 8'd1;
    burst = 8'd1;
    start = 4'b1111;
    repeat (4) @(negedge clk);
    chk("rr0_pulse", {31'd0, pulse}, 32'd1);
    chk("rr0_id", {30'd0, pulse_id}, 32'd0);
    chk("rr0_pending", {28'd0, pending}, 32'he);
    start = 4'b0000;
    @(negedge clk);
    wait_pulse("rr1", 10, 2'd1);
    wait_pulse("rr2", 10, 2'd2);
    wait_pulse("rr3", 10, 2'd3);
    repeat (3) @(negedge clk);
    start = 4'b1001;
    wait_pulse("rrb0", 12, 2'd0);
    start = 4'b0000;
    wait_pulse("rrb3", 12, 2'd3);
    // re-request during own burst merges into one extra burst
    repeat (4) @(negedge clk);
    gap = 8'd4;
    burst = 8'd3;
    start = 4'b0010;
    repeat (4) @(negedge clk);
    chk("rq_pulse", {31'd0, pulse}, 32'd1);
    chk("rq_id", {30'd0, pulse_id}, 32'd1);
    start = 4'b0000;
    repeat (2) @(negedge clk);
    start = 4'b0010;
    repeat (2) @(negedge clk);
    start = 4'b0000;
    repeat (2) @(negedge clk);
    start = 4'b0010;
    repeat (2) @(negedge clk);
    start = 4'b0000;
    chk("rq_pending", {28'd0, pending}, 32'h2);
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pulse) begin
        npulse++;
        chk("rq_burst_id", {30'd0, pulse_id}, 32'd1);
      end
    end
    chk("rq_count", npulse, 32'd4);
    chk("rq_end_pending", {28'd0, pending}, 32'd0);
    chk("rq_end_busy", {31'd0, busy}, 32'd0);
`ifdef PULSE_SCHED_ABORT_EN
    gap = 8'd5;
    burst = 8'd2;
    start = 4'b0101;
    repeat (4) @(negedge clk);
    chk("ab_pulse", {31'd0, pulse}, 32'd1);
    chk("ab_id", {30'd0, pulse_id}, 32'd2);
    chk("ab_pending", {28'd0, pending}, 32'h1);
    start = 4'b0000;
    repeat (2) @(negedge clk);
    chk("ab_gap_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_pulse0", {31'd0, pulse}, 32'd0);
    chk("ab_busy0", {31'd0, busy}, 32'd0);
    chk("ab_pending0", {28'd0, pending}, 32'd0);
    chk("ab_done0", {31'd0, done}, 32'd0);
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pulse) npulse++;
    end
    chk("ab_quiet", npulse, 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
